hub75_row_prefetch: RTL and testbench
=====================================

// Module: hub75_row_prefetch
// PURPOSE
//  Ping-pong scanline buffer between the HDMI framebuffer read port and the HUB75 shifter.
//  Prefetches row N+1 from the framebuffer while the shifter clocks out row N from the other bank.
//  Decouples the shifter from framebuffer read latency. Supplies the row address for led_addr.
// PARAMETERS
//  X_BITS      6             log2(row width)
//  Y_BITS      5             log2(row count)
//  WIDTH       1<<X_BITS     pixels per row
//  HEIGHT      1<<Y_BITS     rows per frame
//  DEPTH       8             bits per colour channel
//  FB_LATENCY  2             cycles from fb_xaddr/fb_yaddr to fb_r/g/b valid (>=1)
//  UNDER_BITS  8             width of the saturating underrun counter
// PORTS
//  clk_48mhz      in   1           system clock; all logic on its rising edge
//  reset          in   1           synchronous, active-high
//  fb_xaddr       out  X_BITS      framebuffer read column
//  fb_yaddr       out  Y_BITS      framebuffer read row
//  fb_r/fb_g/fb_b in   DEPTH each  framebuffer data, FB_LATENCY cycles after address
//  drv_swap       in   1           1-cycle pulse from shifter: request next row
//  drv_xaddr      in   X_BITS      shifter read column, front bank
//  drv_r/g/b      out  DEPTH each  front-bank pixel, registered, 1-cycle latency
//  drv_yaddr      out  Y_BITS      row held in the front bank
//  row_ready      out  1           back bank full; next drv_swap will be accepted
//  underrun_count out  UNDER_BITS  swaps refused because back bank not ready; saturates
// BEHAVIOUR
//  Reset values
//   fb_xaddr=0, fb_yaddr=0, drv_r/g/b=0, drv_yaddr=0, row_ready=0, underrun_count=0.
//   front=bank0, fill_row=0, state=FILL, pipeline valids cleared.
//   Reset mid-fill discards all in-flight reads.
//  FSM
//   FILL: issue fb_xaddr=0..WIDTH-1, one per cycle, fb_yaddr=fill_row.
//     A FB_LATENCY-deep shift register carries {valid,x}.
//     Each valid slot writes {r,g,b} to back[x] on arrival.
//     After the x=WIDTH-1 write lands: row_ready<=1, go to FULL.
//     Fill takes WIDTH+FB_LATENCY cycles from first address.
//   FULL: idle, holding the back bank.
//     On drv_swap: front<=back, drv_yaddr<=fill_row, fill_row<=fill_row+1 (wraps HEIGHT-1->0),
//     row_ready<=0, then FILL the new back bank starting next cycle.
//  Swap refusal
//   drv_swap while row_ready=0 is refused: no bank swap; front and drv_yaddr unchanged,
//   so the shifter repeats its row; underrun_count+1, saturating at all-ones.
//   This includes a swap during FILL and a swap in the cycle the last fill write lands.
//  Read path
//   drv_r/g/b <= front[drv_xaddr] every cycle.
//   Read and swap in the same cycle: the read returns the OLD front bank.
//  Address bus
//   fb_xaddr/fb_yaddr hold their last value outside FILL.
//   The back bank is never read by the driver path; the front bank is never written.
//  Storage
//   Banks: 2*WIDTH words of 3*DEPTH bits. Inferred as block RAM, with read address and
//   bank select as address MSB.
// TESTING
//  1. Reset, fb model returns r=x,g=y,b=x^y after 2 cycles.
//     -> row_ready rises exactly WIDTH+2 cycles after the first fb_xaddr=0.
//     -> back bank holds row 0.
//  2. Swap when ready, then read x=5.
//     -> drv_yaddr=0; drv_r=5, drv_g=0, drv_b=5 one cycle later.
//     -> the next fill issues fb_yaddr=1.
//  3. Pulse drv_swap mid-fill.
//     -> underrun_count=1; drv_yaddr unchanged; fill completes normally.
//  4. Swap HEIGHT+1 times, waiting for row_ready before each.
//     -> drv_yaddr sequence 0..31,0 (wrap); no underruns.
//  5. Assert reset at x=20 of a fill.
//     -> all outputs return to reset values; the refill restarts at x=0, row 0.
//     -> no stale writes land after reset.
//  6. Issue 300 refused swaps.
//     -> underrun_count saturates at 255.
//  7. Read x=63 in the same cycle as an accepted swap.
//     -> returns the old front pixel; the next read returns the new row.

Source files
------------

// File: rtl/hub75_row_prefetch.sv
// Ping-pong scanline buffer: prefetches the next framebuffer row into the
// back bank while the HUB75 shifter reads the front bank.
module hub75_row_prefetch #(
  parameter int X_BITS     = 6,
  parameter int Y_BITS     = 5,
  parameter int DEPTH      = 8,
  parameter int FB_LATENCY = 2,
  parameter int UNDER_BITS = 8,
  localparam int WIDTH     = 1 << X_BITS
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  output logic [X_BITS-1:0]     fb_xaddr_o,
  output logic [Y_BITS-1:0]     fb_yaddr_o,
  input  logic [DEPTH-1:0]      fb_r_i,
  input  logic [DEPTH-1:0]      fb_g_i,
  input  logic [DEPTH-1:0]      fb_b_i,
  input  logic                  drv_swap_i,
  input  logic [X_BITS-1:0]     drv_xaddr_i,
  output logic [DEPTH-1:0]      drv_r_o,
  output logic [DEPTH-1:0]      drv_g_o,
  output logic [DEPTH-1:0]      drv_b_o,
  output logic [Y_BITS-1:0]     drv_yaddr_o,
  output logic                  row_ready_o,
  output logic [UNDER_BITS-1:0] underrun_count_o
);

  typedef enum logic {S_FILL, S_FULL} state_t;

  state_t                state_q, state_d;
  logic                  front_q, front_d;
  logic [Y_BITS-1:0]     fill_row_q, fill_row_d;
  logic [X_BITS-1:0]     xaddr_q, xaddr_d;
  logic [Y_BITS-1:0]     yaddr_q, yaddr_d;
  logic                  issue_q, issue_d;
  logic [Y_BITS-1:0]     drv_y_q, drv_y_d;
  logic                  ready_q, ready_d;
  logic [UNDER_BITS-1:0] under_q, under_d;

  logic [FB_LATENCY-1:0] pv_q;
  logic [X_BITS-1:0]     px_q [FB_LATENCY];
  logic [3*DEPTH-1:0]    mem_q [2*WIDTH];
  logic [3*DEPTH-1:0]    rgb_q;

  logic accept;
  logic refuse;
  logic last_wr;
  logic wr_en;

  assign accept  = drv_swap_i & ready_q;
  assign refuse  = drv_swap_i & ~ready_q;
  assign wr_en   = pv_q[FB_LATENCY-1] & ~reset;
  assign last_wr = pv_q[FB_LATENCY-1] && (px_q[FB_LATENCY-1] == '1);

  always_comb begin
    state_d    = state_q;
    front_d    = front_q;
    fill_row_d = fill_row_q;
    xaddr_d    = xaddr_q;
    yaddr_d    = yaddr_q;
    issue_d    = issue_q;
    drv_y_d    = drv_y_q;
    ready_d    = ready_q;
    under_d    = under_q;
    unique case (state_q)
      S_FILL: begin
        if (issue_q) begin
          if (xaddr_q == '1) issue_d = 1'b0;
          else               xaddr_d = xaddr_q + 1'b1;
        end
        if (last_wr) begin
          ready_d = 1'b1;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (accept) begin
          front_d    = ~front_q;
          drv_y_d    = fill_row_q;
          fill_row_d = fill_row_q + 1'b1;
          ready_d    = 1'b0;
          xaddr_d    = '0;
          yaddr_d    = fill_row_q + 1'b1;
          issue_d    = 1'b1;
          state_d    = S_FILL;
        end
      end
      default: ;
    endcase
    // Refused swaps leave the front bank alone so the shifter repeats its row
    if (refuse && under_q != '1) under_d = under_q + 1'b1;
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q    <= S_FILL;
      front_q    <= 1'b0;
      fill_row_q <= '0;
      xaddr_q    <= '0;
      yaddr_q    <= '0;
      issue_q    <= 1'b1;
      drv_y_q    <= '0;
      ready_q    <= 1'b0;
      under_q    <= '0;
    end else begin
      state_q    <= state_d;
      front_q    <= front_d;
      fill_row_q <= fill_row_d;
      xaddr_q    <= xaddr_d;
      yaddr_q    <= yaddr_d;
      issue_q    <= issue_d;
      drv_y_q    <= drv_y_d;
      ready_q    <= ready_d;
      under_q    <= under_d;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= issue_q & (state_q == S_FILL);
      for (int i = 1; i < FB_LATENCY; i++) pv_q[i] <= pv_q[i-1];
    end
  end

  always_ff @(posedge clk_48mhz) begin
    px_q[0] <= xaddr_q;
    for (int i = 1; i < FB_LATENCY; i++) px_q[i] <= px_q[i-1];
  end

  always_ff @(posedge clk_48mhz) begin
    if (wr_en)
      mem_q[{~front_q, px_q[FB_LATENCY-1]}] <= {fb_r_i, fb_g_i, fb_b_i};
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= mem_q[{front_q, drv_xaddr_i}];
  end

  assign fb_xaddr_o       = xaddr_q;
  assign fb_yaddr_o       = yaddr_q;
  assign {drv_r_o, drv_g_o, drv_b_o} = rgb_q;
  assign drv_yaddr_o      = drv_y_q;
  assign row_ready_o      = ready_q;
  assign underrun_count_o = under_q;

endmodule

// File: tb/tb_hub75_row_prefetch.sv
// Directed bench for hub75_row_prefetch with a 2-cycle framebuffer model
// returning r=x, g=y, b=x^y.
module tb_hub75_row_prefetch;

  logic       clk_48mhz = 1'b0;
  logic       reset;
  logic [5:0] fb_xaddr;
  logic [4:0] fb_yaddr;
  logic [7:0] fb_r, fb_g, fb_b;
  logic       drv_swap;
  logic [5:0] drv_xaddr;
  logic [7:0] drv_r, drv_g, drv_b;
  logic [4:0] drv_yaddr;
  logic       row_ready;
  logic [7:0] underrun_count;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk_48mhz = ~clk_48mhz;

  hub75_row_prefetch dut (
    .clk_48mhz        (clk_48mhz),
    .reset            (reset),
    .fb_xaddr_o       (fb_xaddr),
    .fb_yaddr_o       (fb_yaddr),
    .fb_r_i           (fb_r),
    .fb_g_i           (fb_g),
    .fb_b_i           (fb_b),
    .drv_swap_i       (drv_swap),
    .drv_xaddr_i      (drv_xaddr),
    .drv_r_o          (drv_r),
    .drv_g_o          (drv_g),
    .drv_b_o          (drv_b),
    .drv_yaddr_o      (drv_yaddr),
    .row_ready_o      (row_ready),
    .underrun_count_o (underrun_count)
  );

  logic [7:0]  mx, my;
  logic [23:0] s1, s2;
  assign mx = {2'b0, fb_xaddr};
  assign my = {3'b0, fb_yaddr};
  always @(posedge clk_48mhz) begin
    s1 <= {mx, my, mx ^ my};
    s2 <= s1;
  end
  assign {fb_r, fb_g, fb_b} = s2;

  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_48mhz);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!row_ready && n < 500) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_fbx"}, fb_xaddr, 0);
    check({tag, "_fby"}, fb_yaddr, 0);
    check({tag, "_rgb"}, {drv_r, drv_g, drv_b}, 0);
    check({tag, "_dy"}, drv_yaddr, 0);
    check({tag, "_rdy"}, row_ready, 0);
    check({tag, "_und"}, underrun_count, 0);
  endtask

  initial begin
    int n;
    int refused;
    int exp_u;
    reset     = 1'b1;
    drv_swap  = 1'b0;
    drv_xaddr = '0;
    tick();
    tick();
    check_reset_vals("t1_rst");

    // 1: first fill
    reset = 1'b0;
    wait_ready(n);
    check("t1_fill_cycles", n, 66);

    // 2: accepted swap then read
    drv_swap = 1'b1;
    tick();
    drv_swap = 1'b0;
    check("t2_dy", drv_yaddr, 0);
    check("t2_rdy", row_ready, 0);
    check("t2_fby", fb_yaddr, 1);
    check("t2_fbx", fb_xaddr, 0);
    drv_xaddr = 6'd5;
    tick();
    check("t2_x5", {drv_r, drv_g, drv_b}, {8'd5, 8'd0, 8'd5});
    drv_xaddr = 6'd63;
    tick();
    check("t2_x63", {drv_r, drv_g, drv_b}, {8'd63, 8'd0, 8'd63});

    // 3: swap during fill is refused
    drv_swap = 1'b1;
    tick();
    drv_swap = 1'b0;
    check("t3_und", underrun_count, 1);
    check("t3_dy", drv_yaddr, 0);
    wait_ready(n);
    check("t3_fill_rest", n, 63);

    // 7: read concurrent with accepted swap returns old front
    drv_xaddr = 6'd63;
    drv_swap  = 1'b1;
    tick();
    drv_swap = 1'b0;
    check("t7_old", {drv_r, drv_g, drv_b}, {8'd63, 8'd0, 8'd63});
    check("t7_dy", drv_yaddr, 1);
    tick();
    check("t7_new", {drv_r, drv_g, drv_b}, {8'd63, 8'd1, 8'd62});

    // 5: reset at x=20 of the row-2 fill
    n = 0;
    while (fb_xaddr != 6'd20 && n < 200) begin
      tick();
      n++;
    end
    check("t5_reach_x20", fb_xaddr, 20);
    check("t5_fby2", fb_yaddr, 2);
    reset = 1'b1;
    tick();
    check_reset_vals("t5_rst");
    tick();
    reset = 1'b0;
    check("t5_fby0", fb_yaddr, 0);
    wait_ready(n);
    check("t5_refill", n, 66);

    // 4: HEIGHT+1 swaps with wrap
    for (int i = 0; i < 33; i++) begin
      wait_ready(n);
      check($sformatf("t4_rdy%0d", i), row_ready, 1);
      drv_swap = 1'b1;
      tick();
      drv_swap = 1'b0;
      check($sformatf("t4_dy%0d", i), drv_yaddr, i % 32);
    end
    check("t4_und", underrun_count, 0);
    drv_xaddr = 6'd20;
    tick();
    check("t4_x20", {drv_r, drv_g, drv_b}, {8'd20, 8'd0, 8'd20});

    // 6: saturating underrun counter
    refused = 0;
    n = 0;
    while (refused < 300 && n < 2000) begin
      drv_swap = 1'b1;
      if (!row_ready) refused++;
      tick();
      n++;
      exp_u = (refused > 255) ? 255 : refused;
      if (refused == 100 || refused == 255 || refused == 300)
        check($sformatf("t6_und%0d", refused), underrun_count, exp_u);
    end
    drv_swap = 1'b0;
    check("t6_refused", refused, 300);
    check("t6_sat", underrun_count, 255);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
